ps2_scan_rx: RTL and testbench
==============================

PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the idle clk cycles mid-frame after which a partial frame is abandoned (1 ms at 50 MHz).
REQ-002 SHALL have parameter FIFO_AW, default 3, meaning the log2 of the FIFO depth (8 entries).
REQ-003 SHALL have port clk, input, 1 bit: system clock. The block uses one clock only.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port ps2_clk, input, 1 bit: raw PS/2 keyboard clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1 bit: raw PS/2 keyboard data, asynchronous to clk.
REQ-007 SHALL have port nextdata, input, 1 bit: pop request, active-high, one entry per clk cycle it is high.
REQ-008 SHALL have port scan_code, output, 8 bits: make code at the FIFO head (first-word fall-through), feeding the scan-code-to-ASCII translator.
REQ-009 SHALL have port ready, output, 1 bit: high when the FIFO is non-empty.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, high once a code has been dropped because the FIFO was full.

Function
REQ-011 SHALL synchronize ps2_clk through a 3-flop shift register; a falling edge is the two oldest stages equal to 1 then 0.
REQ-012 SHALL synchronize ps2_data through 2 flops and sample it only on a detected falling edge.
REQ-013 SHALL use a 4-bit bit counter, 0..10, for the frame: start(0), d0..d7 LSB first, odd parity, stop(1).
REQ-014 SHALL wrap the bit counter to 0 on the edge that samples the stop bit.
REQ-015 SHALL accept a frame only if start==0, stop==1, and the XOR of d0..d7 and the parity bit equals 1; otherwise it SHALL discard the frame silently with no state change beyond counter wrap.
REQ-016 SHALL reset the bit counter to 0 and discard the partial frame if no falling edge occurs for TIMEOUT_CYCLES clk cycles while the counter is nonzero.
REQ-017 SHALL implement the decoder FSM with states IDLE, BREAK, and EXT_BREAK.
REQ-018 In IDLE: 0xF0 goes to BREAK, 0xE0 stays in IDLE and is discarded, and any other code is a make code.
REQ-019 In BREAK: 0xE0 goes to EXT_BREAK, and any other code is a released key; the next state is IDLE and nothing is pushed.
REQ-020 In EXT_BREAK: the next code is a released key; the next state is IDLE and nothing is pushed.
REQ-021 SHALL hold an 8-bit register held (reset 0x00) for typematic suppression.
REQ-022 For a make code equal to held, SHALL push nothing.
REQ-023 For a make code not equal to held, SHALL push the code and load held with it.
REQ-024 For a released code equal to held, SHALL clear held to 0x00; a released code not equal to held SHALL leave held unchanged.
REQ-025 SHALL push on the same clk edge that commits the stop bit; ready/scan_code reflect the new entry from that edge.
REQ-026 SHALL implement an 8-entry circular FIFO with wrapping read/write pointers and a 4-bit count.
REQ-027 SHALL make full count==8 and empty count==0.
REQ-028 SHALL ignore a pop when empty.
REQ-029 SHALL drop a push when full and no pop occurs in the same cycle, setting overflow.
REQ-030 For a simultaneous push and pop while full, SHALL accept both, leaving count unchanged.
REQ-031 For a simultaneous push and pop while empty, SHALL accept the push and ignore the pop.
REQ-032 SHALL drive scan_code to 0x00 whenever the FIFO is empty.
REQ-033 SHALL keep overflow high until reset.

Reset
REQ-034 Asserting rst at any time, including mid-frame, SHALL asynchronously clear the sync flops to 1, the bit counter and timeout counter to 0, the FSM to IDLE, held to 0x00, the FIFO pointers/count to 0, scan_code to 0x00, ready to 0, and overflow to 0.
REQ-035 SHALL accept the first full frame beginning after rst deasserts normally.

Verification
REQ-036 Frame 0x1C with parity 0 -> ready=1 and scan_code=0x1C after the stop bit; one nextdata pulse -> ready=0, scan_code=0x00.
REQ-037 Frames 1C, F0, 1C, 1C -> FIFO holds two entries, 0x1C, 0x1C (release clears held).
REQ-038 Typematic 1C, 1C, 1C, then E0 F0 75 interleaved -> a single 0x1C entry is pushed, and the E0 and 75 frames push nothing.
REQ-039 Frame 0x15 with wrong parity, followed by a good 0x15 -> exactly one entry, 0x15.
REQ-040 Nine distinct make codes (each with its break) without pops -> count 8, overflow=1, 9th code absent; pop plus push in the same cycle while full -> count stays 8.
REQ-041 Five bits sent, then either rst or a >TIMEOUT_CYCLES gap, then a full frame 0x29 -> scan_code=0x29, no corruption.

Source files
------------

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, frames and checks each byte,
// filters break/extended prefixes and typematic repeats, and queues make codes in a FWFT FIFO.
module ps2_scan_rx #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_AW        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata,
    output logic [7:0] scan_code,
    output logic       ready,
    output logic       overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BREAK     = 2'd1,
        EXT_BREAK = 2'd2
    } state_t;

    logic [2:0]         r_clk_sync;
    logic [1:0]         r_data_sync;
    logic [3:0]         r_bitcnt;
    logic [9:0]         r_shift;
    logic [TW-1:0]      r_tmo;
    state_t             r_state;
    logic [7:0]         r_held;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wp;
    logic [FIFO_AW-1:0] r_rp;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;

    logic       w_fall;
    logic       w_data;
    logic       w_frame_ok;
    logic [7:0] w_code;
    state_t     w_state_nxt;
    logic [7:0] w_held_nxt;
    logic       w_push;
    logic       w_empty;
    logic       w_full;
    logic       w_pop_ok;
    logic       w_push_ok;

    assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_data = r_data_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
        end
    end

    // Bits 0..9 shift in from the top; the stop bit is judged live when bit 10 arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitcnt <= 4'd0;
            r_shift  <= 10'd0;
            r_tmo    <= '0;
        end else if (w_fall) begin
            r_tmo <= '0;
            if (r_bitcnt == 4'd10) begin
                r_bitcnt <= 4'd0;
            end else begin
                r_bitcnt <= r_bitcnt + 4'd1;
                r_shift  <= {w_data, r_shift[9:1]};
            end
        end else if (r_bitcnt == 4'd0) begin
            r_tmo <= '0;
        end else if (r_tmo == TMO_LAST) begin
            r_tmo    <= '0;
            r_bitcnt <= 4'd0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_code     = r_shift[8:1];
    assign w_frame_ok = w_fall && (r_bitcnt == 4'd10) && !r_shift[0] && w_data
                        && (^r_shift[9:1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_held  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_held  <= w_held_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_held_nxt  = r_held;
        w_push      = 1'b0;
        if (w_frame_ok) begin
            unique case (r_state)
                IDLE: begin
                    if (w_code == 8'hF0) begin
                        w_state_nxt = BREAK;
                    end else if (w_code != 8'hE0 && w_code != r_held) begin
                        w_push     = 1'b1;
                        w_held_nxt = w_code;
                    end
                end
                BREAK: begin
                    if (w_code == 8'hE0) begin
                        w_state_nxt = EXT_BREAK;
                    end else begin
                        w_state_nxt = IDLE;
                        if (w_code == r_held) w_held_nxt = 8'h00;
                    end
                end
                EXT_BREAK: begin
                    w_state_nxt = IDLE;
                    if (w_code == r_held) w_held_nxt = 8'h00;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_pop_ok  = nextdata && !w_empty;
    // When full, a same-cycle pop frees the slot the write pointer lands on.
    assign w_push_ok = w_push && (!w_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wp] <= w_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + 1'b1;
            if (w_pop_ok)  r_rp <= r_rp + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
        end
    end

    assign ready     = !w_empty;
    assign scan_code = w_empty ? 8'h00 : r_mem[r_rp];
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: a vector table of frames/pops/resets plus hand-written
// sequences for overflow, same-cycle push/pop, and mid-frame abandonment.
module tb_ps2_scan_rx;

    localparam int TMO  = 200;
    localparam int HALF = 10;
    localparam int OP_RST = 0;
    localparam int OP_FRM = 1;
    localparam int OP_POP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata = 1'b0;
    logic [7:0] scan_code;
    logic       ready;
    logic       overflow;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        int         op;
        logic [7:0] code;
        logic       bad;
        logic       exp_ready;
        logic [7:0] exp_scan;
    } vec_t;

    vec_t vt[28];

    ps2_scan_rx #(.TIMEOUT_CYCLES(TMO), .FIFO_AW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .nextdata  (nextdata),
        .scan_code (scan_code),
        .ready     (ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One PS/2 bit; optionally raise nextdata for exactly the clk cycle that commits this edge.
    task automatic send_bit(input logic b, input logic pop_here);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (pop_here) begin
            repeat (2) @(negedge clk);
            nextdata = 1'b1;
            @(negedge clk);
            nextdata = 1'b0;
            repeat (HALF - 3) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad, input logic pop_on_stop);
        logic [10:0] bits;
        bits = {1'b1, (~^code) ^ bad, code, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i], pop_on_stop && (i == 10));
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_partial(input int n);
        logic [10:0] bits;
        bits = {1'b1, 1'b1, 8'hFF, 1'b0};
        for (int i = 0; i < n; i++) send_bit(bits[i], 1'b0);
    endtask

    task automatic pop();
        nextdata = 1'b1;
        @(negedge clk);
        nextdata = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] codes [9];
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};

        vt[0]  = '{OP_RST, 8'h00, 1'b0, 1'b0, 8'h00};
        vt[1]  = '{OP_FRM, 8'h1C, 1'b0, 1'b1, 8'h1C};
        vt[2]  = '{OP_POP, 8'h00, 1'b0, 1'b0, 8'h00};
        vt[3]  = '{OP_RST, 8'h00, 1'b0, 1'b0, 8'h00};
        vt[4]  = '{OP_FRM, 8'h1C, 1'b0, 1'b1, 8'h1C};
        vt[5]  = '{OP_FRM, 8'hF0, 1'b0, 1'b1, 8'h1C};
        vt[6]  = '{OP_FRM, 8'h1C, 1'b0, 1'b1, 8'h1C};
        vt[7]  = '{OP_FRM, 8'h1C, 1'b0, 1'b1, 8'h1C};
        vt[8]  = '{OP_POP, 8'h00, 1'b0, 1'b1, 8'h1C};
        vt[9]  = '{OP_POP, 8'h00, 1'b0, 1'b0, 8'h00};
        vt[10] = '{OP_RST, 8'h00, 1'b0, 1'b0, 8'h00};
        vt[11] = '{OP_FRM, 8'h1C, 1'b0, 1'b1, 8'h1C};
        vt[12] = '{OP_FRM, 8'h1C, 1'b0, 1'b1, 8'h1C};
        vt[13] = '{OP_FRM, 8'hE0, 1'b0, 1'b1, 8'h1C};
        vt[14] = '{OP_FRM, 8'h1C, 1'b0, 1'b1, 8'h1C};
        vt[15] = '{OP_FRM, 8'hF0, 1'b0, 1'b1, 8'h1C};
        vt[16] = '{OP_FRM, 8'h75, 1'b0, 1'b1, 8'h1C};
        vt[17] = '{OP_POP, 8'h00, 1'b0, 1'b0, 8'h00};
        vt[18] = '{OP_FRM, 8'h1C, 1'b0, 1'b0, 8'h00};
        vt[19] = '{OP_RST, 8'h00, 1'b0, 1'b0, 8'h00};
        vt[20] = '{OP_FRM, 8'h15, 1'b1, 1'b0, 8'h00};
        vt[21] = '{OP_FRM, 8'h15, 1'b0, 1'b1, 8'h15};
        vt[22] = '{OP_POP, 8'h00, 1'b0, 1'b0, 8'h00};
        vt[23] = '{OP_FRM, 8'hF0, 1'b0, 1'b0, 8'h00};
        vt[24] = '{OP_FRM, 8'hE0, 1'b0, 1'b0, 8'h00};
        vt[25] = '{OP_FRM, 8'h15, 1'b0, 1'b0, 8'h00};
        vt[26] = '{OP_FRM, 8'h15, 1'b0, 1'b1, 8'h15};
        vt[27] = '{OP_POP, 8'h00, 1'b0, 1'b0, 8'h00};

        for (int i = 0; i < 28; i++) begin
            case (vt[i].op)
                OP_RST:  do_reset();
                OP_FRM:  send_frame(vt[i].code, vt[i].bad, 1'b0);
                default: pop();
            endcase
            chk($sformatf("vec%0d ready", i), {7'd0, ready}, {7'd0, vt[i].exp_ready});
            chk($sformatf("vec%0d scan_code", i), scan_code, vt[i].exp_scan);
            chk($sformatf("vec%0d overflow", i), {7'd0, overflow}, 8'h00);
        end

        // Push and pop in the same cycle while empty: push wins.
        do_reset();
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("empty push+pop ready", {7'd0, ready}, 8'h01);
        chk("empty push+pop scan", scan_code, 8'h1C);

        // Fill past capacity with make/break pairs.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send_frame(codes[i], 1'b0, 1'b0);
            send_frame(8'hF0, 1'b0, 1'b0);
            send_frame(codes[i], 1'b0, 1'b0);
            if (i < 8) exp_q.push_back(codes[i]);
            if (i == 7) begin
                chk("fill8 count", {4'd0, dut.r_count}, 8'd8);
                chk("fill8 overflow", {7'd0, overflow}, 8'h00);
            end
        end
        chk("ovf count", {4'd0, dut.r_count}, 8'd8);
        chk("ovf flag", {7'd0, overflow}, 8'h01);
        chk("ovf head", scan_code, 8'h1C);

        // Full: push and pop together keeps count at 8.
        send_frame(8'h44, 1'b0, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h44);
        chk("full push+pop count", {4'd0, dut.r_count}, 8'd8);
        chk("full push+pop head", scan_code, 8'h32);
        chk("full push+pop overflow", {7'd0, overflow}, 8'h01);

        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("drain ready", {7'd0, ready}, 8'h01);
            chk("drain scan", scan_code, e);
            pop();
        end
        chk("drained ready", {7'd0, ready}, 8'h00);
        chk("drained scan", scan_code, 8'h00);
        chk("overflow sticky", {7'd0, overflow}, 8'h01);

        // Reset in mid-frame clears everything, then a clean frame lands.
        send_partial(5);
        do_reset();
        chk("midrst overflow", {7'd0, overflow}, 8'h00);
        chk("midrst ready", {7'd0, ready}, 8'h00);
        chk("midrst bitcnt", {4'd0, dut.r_bitcnt}, 8'h00);
        send_frame(8'h29, 1'b0, 1'b0);
        chk("midrst 29 scan", scan_code, 8'h29);
        pop();
        chk("midrst single", {7'd0, ready}, 8'h00);

        // Abandoned partial frame via timeout.
        send_partial(5);
        repeat (TMO + 60) @(negedge clk);
        send_frame(8'h29, 1'b0, 1'b0);
        chk("tmo 29 ready", {7'd0, ready}, 8'h00);
        // 0x29 equals held from the previous frame; release then re-send.
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0, 1'b0);
        send_partial(5);
        repeat (TMO + 60) @(negedge clk);
        send_frame(8'h29, 1'b0, 1'b0);
        chk("tmo 29 scan", scan_code, 8'h29);
        pop();
        chk("tmo single", {7'd0, ready}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
